// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART TX byte channel between NUM_REQ packet sources.
// Each granted packet is prefixed with a {4'hA, source id} header; stalled sources are aborted.
module uart_tx_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_valid,
    output logic [7:0]           tx_data,
    input  logic                 tx_ready,
    output logic [3:0]           grant_id,
    output logic                 busy,
    output logic                 abort_pulse,
    output logic [CNT_W-1:0]     pkt_count
);

    localparam int SW = $clog2(TIMEOUT);
    localparam logic [SW-1:0] STALL_MAX = SW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAYLOAD
    } state_t;

    state_t        state;
    logic [3:0]    rr_ptr;
    logic [SW-1:0] stall_cnt;

    logic          g_valid;
    logic          g_last;
    logic [7:0]    g_data;
    logic          any_req;
    logic [3:0]    winner;
    int            win_dist;
    int            cand_dist;

    // Mux out the granted source's byte lane without a variable-width index.
    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_id == 4'(i)) begin
                g_valid = req_valid[i];
                g_last  = req_last[i];
                g_data  = req_data[8*i +: 8];
            end
        end
    end

    // Winner is the valid source at the smallest rotational distance after rr_ptr.
    always_comb begin
        any_req   = 1'b0;
        winner    = '0;
        win_dist  = NUM_REQ;
        cand_dist = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand_dist = int'(i) - int'(rr_ptr) - 1;
            if (cand_dist < 0) begin
                cand_dist = cand_dist + NUM_REQ;
            end
            if (req_valid[i] && (cand_dist < win_dist)) begin
                any_req  = 1'b1;
                winner   = 4'(i);
                win_dist = cand_dist;
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state       <= IDLE;
            rr_ptr      <= 4'(NUM_REQ - 1);
            grant_id    <= '0;
            pkt_count   <= '0;
            stall_cnt   <= '0;
            abort_pulse <= 1'b0;
        end else begin
            abort_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_id <= winner;
                        state    <= HDR;
                    end
                end
                HDR: begin
                    stall_cnt <= '0;
                    if (tx_ready) begin
                        state <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (g_valid && tx_ready) begin
                        stall_cnt <= '0;
                        if (g_last) begin
                            state     <= IDLE;
                            rr_ptr    <= grant_id;
                            pkt_count <= pkt_count + 1'b1;
                        end
                    end else if (!g_valid) begin
                        // Only source-side silence counts; downstream backpressure never aborts.
                        if (stall_cnt == STALL_MAX) begin
                            abort_pulse <= 1'b1;
                            state       <= IDLE;
                            rr_ptr      <= grant_id;
                            stall_cnt   <= '0;
                        end else begin
                            stall_cnt <= stall_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state != IDLE);
        tx_valid  = 1'b0;
        tx_data   = '0;
        req_ready = '0;
        case (state)
            HDR: begin
                tx_valid = 1'b1;
                tx_data  = {4'hA, grant_id};
            end
            PAYLOAD: begin
                tx_valid = g_valid;
                tx_data  = g_data;
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    req_ready[i] = (grant_id == 4'(i)) && tx_ready;
                end
            end
            default: begin
                tx_valid = 1'b0;
            end
        endcase
    end

endmodule
